// File: rtl/embed_sample_logger.sv
`default_nettype none
// ============================================================================
//  Module      : embed_sample_logger
//  Description : Streams 32-bit samples into a single-port on-chip RAM used
//                as a circular log buffer. Optionally zero-fills the RAM
//                after reset or clear, and tracks the write pointer, the fill
//                level and a sticky overflow flag.
//                Optional feature macro: LOGGER_TIMESTAMP_EN. When it is
//                defined, every sample is preceded by a 32-bit cycle-count
//                timestamp word.
//  Revision    : 1.0 - initial release
// ============================================================================
module embed_sample_logger #(
    parameter int DEPTH_LOG2     = 12,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  sample_valid,
    input  logic [31:0]           sample_data,
    output logic                  sample_ready,
    output logic [DEPTH_LOG2-1:0] ram_address,
    output logic [3:0]            ram_byteenable,
    output logic                  ram_chipselect,
    output logic                  ram_write,
    output logic [31:0]           ram_writedata,
    output logic                  ram_clken,
    output logic [DEPTH_LOG2-1:0] wr_ptr,
    output logic [DEPTH_LOG2:0]   fill_count,
    output logic                  overflow,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    localparam state_t                RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
    localparam logic [DEPTH_LOG2-1:0] LAST_ADDR   = '1;
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT  = {1'b1, {DEPTH_LOG2{1'b0}}};

    state_t                state_q,    state_d;
    logic [DEPTH_LOG2-1:0] clr_addr_q, clr_addr_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q,   wr_ptr_d;
    logic [DEPTH_LOG2:0]   fill_q,     fill_d;
    logic                  ovf_q,      ovf_d;
    logic                  busy_q,     busy_d;
    logic                  wr_q,       wr_d;
    logic [DEPTH_LOG2-1:0] addr_q,     addr_d;
    logic [31:0]           data_q,     data_d;
    logic [3:0]            be_q,       be_d;
    logic                  clken_q,    clken_d;
`ifdef LOGGER_TIMESTAMP_EN
    logic [31:0]           ts_q,        ts_d;
    logic                  pend_q,      pend_d;
    logic [31:0]           pend_data_q, pend_data_d;
`endif

    logic                  ready;
    logic                  word_issue;
    logic [31:0]           word_data;

    // Sample handshake: only while running, enabled, not clearing, and
    // (with timestamps) not busy emitting the second word of a pair.
    always_comb begin
        ready = (state_q == S_RUN) && enable && !clear;
`ifdef LOGGER_TIMESTAMP_EN
        ready = ready && !pend_q;
`endif
    end

    // Next-state, buffer bookkeeping and the registered RAM command.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        wr_ptr_d   = wr_ptr_q;
        fill_d     = fill_q;
        ovf_d      = ovf_q;
        busy_d     = 1'b0;
        wr_d       = 1'b0;
        addr_d     = '0;
        data_d     = '0;
        be_d       = 4'h0;
        clken_d    = 1'b1;
        word_issue = 1'b0;
        word_data  = '0;
`ifdef LOGGER_TIMESTAMP_EN
        ts_d        = ts_q + 32'd1;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
`endif
        if (clear) begin
            // Clear beats everything, including a sample offered this cycle.
            state_d    = RESET_STATE;
            clr_addr_d = '0;
            wr_ptr_d   = '0;
            fill_d     = '0;
            ovf_d      = 1'b0;
            busy_d     = (RESET_STATE == S_CLEAR);
`ifdef LOGGER_TIMESTAMP_EN
            pend_d     = 1'b0;
`endif
        end else begin
            case (state_q)
                S_CLEAR: begin
                    wr_d       = 1'b1;
                    be_d       = 4'hF;
                    addr_d     = clr_addr_q;
                    busy_d     = 1'b1;
                    clr_addr_d = clr_addr_q + DEPTH_LOG2'(1);
                    if (clr_addr_q == LAST_ADDR) begin
                        state_d = S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (enable) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
`ifdef LOGGER_TIMESTAMP_EN
                    if (pend_q) begin
                        word_issue = 1'b1;
                        word_data  = pend_data_q;
                        pend_d     = 1'b0;
                    end else if (sample_valid && ready) begin
                        word_issue  = 1'b1;
                        word_data   = ts_q;
                        pend_d      = 1'b1;
                        pend_data_d = sample_data;
                    end
                    if (!enable && !pend_q) begin
                        state_d = S_IDLE;
                    end
`else
                    if (sample_valid && ready) begin
                        word_issue = 1'b1;
                        word_data  = sample_data;
                    end
                    if (!enable) begin
                        state_d = S_IDLE;
                    end
`endif
                end
                default: begin
                    state_d = RESET_STATE;
                end
            endcase

            if (word_issue) begin
                wr_d     = 1'b1;
                be_d     = 4'hF;
                addr_d   = wr_ptr_q;
                data_d   = word_data;
                wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
                if (fill_q == FULL_COUNT) begin
                    ovf_d = 1'b1;
                end else begin
                    fill_d = fill_q + (DEPTH_LOG2+1)'(1);
                end
            end
        end
    end

    // State and output registers; reset aborts any fill or run in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RESET_STATE;
            clr_addr_q <= '0;
            wr_ptr_q   <= '0;
            fill_q     <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            be_q       <= 4'h0;
            clken_q    <= 1'b0;
`ifdef LOGGER_TIMESTAMP_EN
            ts_q        <= '0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_q     <= fill_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            be_q       <= be_d;
            clken_q    <= clken_d;
`ifdef LOGGER_TIMESTAMP_EN
            ts_q        <= ts_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
`endif
        end
    end

    assign sample_ready   = ready;
    assign ram_address    = addr_q;
    assign ram_byteenable = be_q;
    assign ram_chipselect = wr_q;
    assign ram_write      = wr_q;
    assign ram_writedata  = data_q;
    assign ram_clken      = clken_q;
    assign wr_ptr         = wr_ptr_q;
    assign fill_count     = fill_q;
    assign overflow       = ovf_q;
    assign busy           = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_embed_sample_logger.sv
`default_nettype none
// ============================================================================
//  Module      : tb_embed_sample_logger
//  Description : Scoreboard bench for embed_sample_logger. A buffer model
//                predicts every RAM write into a queue; a monitor pops and
//                compares each write the DUT presents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_embed_sample_logger;

    localparam int DL    = 12;
    localparam int DEPTH = 1 << DL;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          clear = 1'b0;
    logic          sample_valid = 1'b0;
    logic [31:0]   sample_data = '0;
    logic          sample_ready;
    logic [DL-1:0] ram_address;
    logic [3:0]    ram_byteenable;
    logic          ram_chipselect;
    logic          ram_write;
    logic [31:0]   ram_writedata;
    logic          ram_clken;
    logic [DL-1:0] wr_ptr;
    logic [DL:0]   fill_count;
    logic          overflow;
    logic          busy;

    embed_sample_logger #(.DEPTH_LOG2(DL), .CLEAR_ON_RESET(1)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
        .sample_valid(sample_valid), .sample_data(sample_data),
        .sample_ready(sample_ready), .ram_address(ram_address),
        .ram_byteenable(ram_byteenable), .ram_chipselect(ram_chipselect),
        .ram_write(ram_write), .ram_writedata(ram_writedata),
        .ram_clken(ram_clken), .wr_ptr(wr_ptr), .fill_count(fill_count),
        .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DL-1:0] a;
        logic [31:0]   d;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    int          n_tests = 0;
    int          n_fail = 0;
    int          n_pops = 0;
    int          busy_cycles = 0;
    int unsigned cyc = 0;

    // Buffer model state
    int          m_ptr = 0;
    int          m_fill = 0;
    bit          m_ovf = 1'b0;
    bit          m_run = 1'b0;
    bit          m_block = 1'b0;
    int          m_acc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Free-running cycle reference for the timestamp words
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    // Monitor: every RAM write must match the head of the expectation queue
    always @(negedge clk) begin
        if (reset_n && busy) busy_cycles++;
        if (ram_write || ram_chipselect) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: addr=%0h data=%0h with nothing expected (t=%0t)",
                         ram_address, ram_writedata, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("ram_write", {14'd0, ram_chipselect, ram_write, ram_byteenable, ram_address, ram_writedata},
                    {14'd0, 1'b1, 1'b1, 4'hF, mon_e.a, mon_e.d});
                n_pops++;
            end
        end
    end

    function automatic void push_word(input logic [31:0] w);
        exp_q.push_back('{a: DL'(m_ptr), d: w});
        m_ptr = (m_ptr + 1) % DEPTH;
        if (m_fill == DEPTH) m_ovf = 1'b1;
        else                 m_fill++;
    endfunction

    function automatic void push_fill();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back('{a: DL'(i), d: 32'h0});
    endfunction

    function automatic void model_zero();
        m_ptr   = 0;
        m_fill  = 0;
        m_ovf   = 1'b0;
        m_run   = 1'b0;
        m_block = 1'b0;
    endfunction

    // One clock of stimulus; checks the handshake against the model
    task automatic step(input bit en, input bit clr, input bit v, input logic [31:0] d);
        bit blk;
        bit exp_rdy;
        @(posedge clk);
        #1;
        enable = en; clear = clr; sample_valid = v; sample_data = d;
        #1;
        blk     = m_block;
        m_block = 1'b0;
        exp_rdy = m_run && en && !clr && !blk;
        chk("sample_ready", {63'd0, sample_ready}, {63'd0, exp_rdy});
        if (clr) begin
            model_zero();
            push_fill();
        end else begin
            if (v && exp_rdy) begin
                m_acc++;
`ifdef LOGGER_TIMESTAMP_EN
                push_word(cyc);
                push_word(d);
                m_block = 1'b1;
`else
                push_word(d);
`endif
            end
            m_run = en || blk;
        end
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_wr_ptr"},     {52'd0, wr_ptr},       64'(m_ptr));
        chk({tag, "_fill_count"}, {51'd0, fill_count},   64'(m_fill));
        chk({tag, "_overflow"},   {63'd0, overflow},     {63'd0, m_ovf});
    endtask

    task automatic drain(input string tag, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (exp_q.size() == 0) break;
            step(1'b0, 1'b0, 1'b0, 32'h0);
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d writes still outstanding, required 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int base;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst_sample_ready", {63'd0, sample_ready},   64'd0);
        chk("rst_chipselect",   {63'd0, ram_chipselect}, 64'd0);
        chk("rst_write",        {63'd0, ram_write},      64'd0);
        chk("rst_address",      {52'd0, ram_address},    64'd0);
        chk("rst_writedata",    {32'd0, ram_writedata},  64'd0);
        chk("rst_byteenable",   {60'd0, ram_byteenable}, 64'd0);
        chk("rst_clken",        {63'd0, ram_clken},      64'd0);
        chk("rst_busy",         {63'd0, busy},           64'd0);
        check_status("rst");

        // Release: full zero fill, busy for exactly DEPTH cycles
        busy_cycles = 0;
        model_zero();
        push_fill();
        reset_n = 1'b1;
        drain("init_fill", DEPTH + 100);
        chk("init_busy_cycles", 64'(busy_cycles), 64'(DEPTH));
        chk("clken_out_of_reset", {63'd0, ram_clken}, 64'd1);
        check_status("post_fill");

        // Enable, then three back-to-back samples
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 32'hA5A50001);
        step(1'b1, 1'b0, 1'b1, 32'hA5A50002);
        step(1'b1, 1'b0, 1'b1, 32'hA5A50003);
        repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);
        check_status("three_samples");
`ifndef LOGGER_TIMESTAMP_EN
        chk("three_wr_ptr", {52'd0, wr_ptr},     64'd3);
        chk("three_fill",   {51'd0, fill_count}, 64'd3);
`endif

        // Random traffic with occasional enable drops
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 8) != 0, 1'b0, $urandom % 2, $urandom);
        end
        repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);
        check_status("random");

        // Clear collides with a sample: sample refused, status zeroed, fill restarts
        step(1'b1, 1'b1, 1'b1, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        chk("clr_wr_ptr",   {52'd0, wr_ptr},     64'd0);
        chk("clr_fill",     {51'd0, fill_count}, 64'd0);
        chk("clr_overflow", {63'd0, overflow},   64'd0);
        drain("clear_fill", DEPTH + 100);

        // Wrap and overflow: DEPTH+1 samples
        step(1'b1, 1'b0, 1'b0, 32'h0);
        m_acc = 0;
        for (int i = 0; i < 4 * DEPTH; i++) begin
            if (m_acc >= DEPTH + 1) break;
            step(1'b1, 1'b0, 1'b1, $urandom);
        end
        repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);
        check_status("overflow");
`ifndef LOGGER_TIMESTAMP_EN
        chk("ovf_wr_ptr",   {52'd0, wr_ptr},     64'd1);
        chk("ovf_fill",     {51'd0, fill_count}, 64'(DEPTH));
        chk("ovf_overflow", {63'd0, overflow},   64'd1);
`endif

        // Enable drop / re-enable handshake
        step(1'b0, 1'b0, 1'b1, 32'h11110000);
        step(1'b0, 1'b0, 1'b1, 32'h11110001);
        step(1'b1, 1'b0, 1'b1, 32'h11110002);
        step(1'b1, 1'b0, 1'b1, 32'h11110003);
        repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);
        check_status("reenable");

        // Reset pulse in the middle of a clear fill
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        base = n_pops;
        for (int i = 0; i < DEPTH + 100; i++) begin
            if (n_pops - base >= DEPTH / 2) break;
            step(1'b0, 1'b0, 1'b0, 32'h0);
        end
        chk("midclear_progress", 64'(n_pops - base), 64'(DEPTH / 2));
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_write",   {63'd0, ram_write},   64'd0);
        chk("midrst_address", {52'd0, ram_address}, 64'd0);
        repeat (3) @(posedge clk);
        #2;
        model_zero();
        check_status("midrst");
        busy_cycles = 0;
        push_fill();
        reset_n = 1'b1;
        drain("refill", DEPTH + 100);
        chk("refill_busy_cycles", 64'(busy_cycles), 64'(DEPTH));
        check_status("refill");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/embed_sample_logger.md
EMBED_SAMPLE_LOGGER -- requirements
Module: embed_sample_logger

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 12, meaning RAM word-address width (buffer depth 2^DEPTH_LOG2 words).
REQ-002 SHALL have parameter CLEAR_ON_RESET, default 1, meaning zero-fill the RAM after reset (1) or skip the fill (0).
REQ-003 SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port enable, input, 1, logging enable.
REQ-006 SHALL have port clear, input, 1, synchronous buffer clear request.
REQ-007 SHALL have port sample_valid, input, 1, sample present.
REQ-008 SHALL have port sample_data, input, 32, sample value.
REQ-009 SHALL have port sample_ready, output, 1, sample accepted this cycle when high together with sample_valid.
REQ-010 SHALL have ports ram_address (output, DEPTH_LOG2), ram_byteenable (output, 4), ram_chipselect (output, 1), ram_write (output, 1), ram_writedata (output, 32), ram_clken (output, 1), which drive a single-port on-chip RAM slave with a fixed one-cycle write and no waitrequest.
REQ-011 SHALL have ports wr_ptr (output, DEPTH_LOG2), fill_count (output, DEPTH_LOG2+1), overflow (output, 1), busy (output, 1), which carry the status.

Function
REQ-012 SHALL implement FSM states CLEAR, IDLE and RUN.
REQ-013 CLEAR SHALL write 0x00000000 to words 0..2^DEPTH_LOG2-1 in ascending order, one per cycle, then enter IDLE; busy SHALL be high throughout CLEAR.
REQ-014 IDLE SHALL enter RUN on the cycle after enable is sampled high; RUN SHALL enter IDLE when enable is sampled low and no write is pending.
REQ-015 sample_ready SHALL be high only in RUN, with enable high and clear low.
REQ-016 An accepted sample SHALL be written exactly one cycle later at address wr_ptr, with ram_chipselect=ram_write=1, ram_byteenable=4'hF and ram_writedata=the sample.
REQ-017 wr_ptr SHALL advance by one per RAM data write and wrap from 2^DEPTH_LOG2-1 to 0.
REQ-018 fill_count SHALL increment per written word and saturate at 2^DEPTH_LOG2.
REQ-019 A write while fill_count is at saturation SHALL overwrite the oldest word and set overflow, which is sticky until clear or reset.
REQ-020 clear, sampled high in any state, SHALL zero wr_ptr, fill_count and overflow, drop any pending write, and enter CLEAR (when CLEAR_ON_RESET=1) or IDLE (otherwise).
REQ-021 If clear and sample_valid are high in the same cycle, clear SHALL win and the sample SHALL NOT be accepted.
REQ-022 When no write is issued, ram_chipselect and ram_write SHALL be 0; ram_clken SHALL be 1 at all times out of reset.
REQ-023 enable falling with a write pending SHALL still complete that write.

Reset
REQ-024 reset_n low SHALL asynchronously force all of the following: state=CLEAR (CLEAR_ON_RESET=1) or IDLE; wr_ptr=0; fill_count=0; overflow=0; sample_ready=0; ram_chipselect=0; ram_write=0; ram_address=0; ram_writedata=0; ram_byteenable=0; ram_clken=0; busy=0.
REQ-025 Reset deassertion SHALL take effect on the next rising clk edge.
REQ-026 Reset asserted mid-CLEAR or mid-RUN SHALL abandon the operation with no further RAM writes.

Configuration
REQ-027 Macro LOGGER_TIMESTAMP_EN, when defined, SHALL add a 32-bit free-running cycle counter that is zeroed by reset_n.
REQ-028 With LOGGER_TIMESTAMP_EN defined, each accepted sample SHALL produce two consecutive writes: the counter value at acceptance to wr_ptr, then sample_data to wr_ptr+1.
REQ-029 With LOGGER_TIMESTAMP_EN defined, sample_ready SHALL be low in the cycle of the first write, and wr_ptr and fill_count SHALL advance per word.
REQ-030 Without LOGGER_TIMESTAMP_EN, there SHALL be no counter and exactly one write per sample.

Verification
REQ-031 Reset release with CLEAR_ON_RESET=1 and DEPTH_LOG2=12 -> 4096 writes of 0 to addresses 0..4095; busy high for 4096 cycles; then IDLE.
REQ-032 enable=1; samples 0xA5A50001..0xA5A50003 on back-to-back cycles -> writes at addresses 0,1,2 one cycle after each acceptance; wr_ptr=3; fill_count=3.
REQ-033 4097 samples with DEPTH_LOG2=12 -> the 4097th sample written at address 0; fill_count=4096; overflow=1; wr_ptr=1.
REQ-034 clear and sample_valid high in the same cycle -> no sample write; wr_ptr=0, fill_count=0, overflow=0; CLEAR sequence restarts.
REQ-035 LOGGER_TIMESTAMP_EN defined; sample 0x12345678 accepted with counter=0x00000100 -> writes 0x00000100 then 0x12345678; sample_ready low during the first write; wr_ptr=2.
REQ-036 reset_n pulsed low at CLEAR address 0x800 -> no writes while reset is low; the fill restarts at address 0 after release.
